// File: rtl/logic_unit_pkg.sv
// Shared definitions for the bitwise logic unit: op-code width and op encoding.
package logic_unit_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_ANDN = 3'd6,   // A & ~B
        OP_PASS = 3'd7    // A
    } op_e;

endpackage

// File: rtl/logic_unit_core.sv
// Purely combinational WIDTH-bit bitwise op decode/compute with result flags.
// Optional parity output is enabled by LOGIC_UNIT_PARITY_EN.
module logic_unit_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    output logic [WIDTH-1:0] y,
    output logic             zero,
`ifdef LOGIC_UNIT_PARITY_EN
    output logic             parity,
`endif
    output logic             ones
);

    // Op decode: every op is bitwise, no carry, no width growth.
    always_comb begin
        y = '0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XNOR: y = ~(a ^ b);
            OP_ANDN: y = a & ~b;
            OP_PASS: y = a;
            default: y = '0;
        endcase
    end

    // Flags; for WIDTH=1 these reduce to zero=~y, ones=y.
    assign zero = ~(|y);
    assign ones = &y;

`ifdef LOGIC_UNIT_PARITY_EN
    assign parity = ^y;
`endif

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready pipelined bitwise logic unit.
// S1 registers operands and op, S2 registers the result and flags.
// Define LOGIC_UNIT_PARITY_EN to add the registered out_parity output.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OP_W-1:0]  in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
`ifdef LOGIC_UNIT_PARITY_EN
    output logic             out_parity,
`endif
    output logic             out_ones
);

    // S1 state
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    op_e              op_q, op_d;

    // S2 state
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             zero_q, zero_d;
    logic             ones_q, ones_d;

    // Combinational result of the beat sitting in S1
    logic [WIDTH-1:0] y_c;
    logic             zero_c, ones_c;

    logic s1_adv, s2_adv;

`ifdef LOGIC_UNIT_PARITY_EN
    logic parity_q, parity_d, parity_c;
`endif

    logic_unit_core #(.WIDTH(WIDTH)) u_core (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .y      (y_c),
        .zero   (zero_c),
`ifdef LOGIC_UNIT_PARITY_EN
        .parity (parity_c),
`endif
        .ones   (ones_c)
    );

    // Advance logic: S2 drains when empty or consumed; S1 moves when empty or S2 moves.
    // in_ready depends on out_ready and state only, never on in_valid.
    always_comb begin
        s2_adv = !out_valid_q || out_ready;
        s1_adv = !s1_valid_q || s2_adv;
    end

    assign in_ready = s1_adv;

    // Next-state for both stages; data registers only load on a real beat so
    // out_y keeps its last value across bubbles.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        out_valid_d = out_valid_q;
        y_d         = y_q;
        zero_d      = zero_q;
        ones_d      = ones_q;
`ifdef LOGIC_UNIT_PARITY_EN
        parity_d    = parity_q;
`endif
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                a_d  = in_a;
                b_d  = in_b;
                op_d = op_e'(in_op);
            end
        end
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                y_d    = y_c;
                zero_d = zero_c;
                ones_d = ones_c;
`ifdef LOGIC_UNIT_PARITY_EN
                parity_d = parity_c;
`endif
            end
        end
    end

    // Pipeline registers; reset discards all in-flight beats at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= OP_AND;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            zero_q      <= 1'b0;
            ones_q      <= 1'b0;
`ifdef LOGIC_UNIT_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            s1_valid_q  <= s1_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            zero_q      <= zero_d;
            ones_q      <= ones_d;
`ifdef LOGIC_UNIT_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_y     = y_q;
    assign out_zero  = zero_q;
    assign out_ones  = ones_q;
`ifdef LOGIC_UNIT_PARITY_EN
    assign out_parity = parity_q;
`endif

endmodule
